// File: rtl/bus_region_router_pkg.sv
// Shared state encoding and default region map for the CPU data-port region router.
package bus_router_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCESS = 2'd1;
    localparam state_t ST_RESP   = 2'd2;
    localparam state_t ST_ERR    = 2'd3;

    localparam logic [31:0] MEM_BASE  = 32'h0000_0000;
    localparam logic [31:0] MEM_LIMIT = 32'hBFFF_FFFF;
    localparam logic [31:0] IO_BASE   = 32'hC000_0000;
    localparam logic [31:0] IO_LIMIT  = 32'hFFFF_FFFF;

    // Width of an encoded slave index; a single slave still needs one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_region_router_if.sv
// CPU-side and target-side signals of the region router, bundled as one interface.
interface bus_region_router_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 2
);
    logic [ADDR_WIDTH-1:0]            m_addr;
    logic [DATA_WIDTH-1:0]            m_wdata;
    logic                             m_read;
    logic                             m_write;
    logic [DATA_WIDTH-1:0]            m_rdata;
    logic                             m_ready;
    logic                             m_error;
    logic [NUM_SLAVES*ADDR_WIDTH-1:0] s_addr;
    logic [DATA_WIDTH-1:0]            s_wdata;
    logic [NUM_SLAVES-1:0]            s_read;
    logic [NUM_SLAVES-1:0]            s_write;
    logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata;
    logic [NUM_SLAVES-1:0]            s_ready;

    // Environment view: the CPU and the targets around the router.
    modport master (
        output m_addr, m_wdata, m_read, m_write, s_rdata, s_ready,
        input  m_rdata, m_ready, m_error, s_addr, s_wdata, s_read, s_write
    );

    // Router view.
    modport slave (
        input  m_addr, m_wdata, m_read, m_write, s_rdata, s_ready,
        output m_rdata, m_ready, m_error, s_addr, s_wdata, s_read, s_write
    );
endinterface

// File: rtl/bus_region_router_region_decoder.sv
// Combinational address decoder: in-range test per region, lowest index wins on overlap.
module region_decoder
    import bus_router_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_SLAVES = 2,
    parameter int SEL_WIDTH  = 1,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE  = {IO_BASE, MEM_BASE},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_LIMIT = {IO_LIMIT, MEM_LIMIT}
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [NUM_SLAVES-1:0] o_hit,
    output logic [SEL_WIDTH-1:0]  o_sel,
    output logic                  o_any_hit
);

    logic [NUM_SLAVES-1:0] w_in_range;

    // Inclusive base/limit comparison for every region.
    always_comb begin
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_in_range[i] = (i_addr >= SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) &&
                            (i_addr <= SLAVE_LIMIT[i*ADDR_WIDTH +: ADDR_WIDTH]);
        end
    end

    // Scan from the top so the lowest matching index is the last one written.
    always_comb begin
        o_any_hit = |w_in_range;
        o_sel     = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            o_sel = w_in_range[i] ? SEL_WIDTH'(i) : o_sel;
        end
        for (int j = 0; j < NUM_SLAVES; j++) begin
            o_hit[j] = o_any_hit && (o_sel == SEL_WIDTH'(j));
        end
    end

endmodule

// File: rtl/bus_region_router.sv
// Registered N-way router from the CPU data port to NUM_SLAVES address regions,
// with request/ready handshake, unmapped-address errors and a per-access timeout.
module bus_region_router
    import bus_router_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLAVES     = 2,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE  = {IO_BASE, MEM_BASE},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_LIMIT = {IO_LIMIT, MEM_LIMIT},
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic               clk,
    input  logic               reset,
    bus_region_router_if.slave bus
);

    localparam int SEL_WIDTH = sel_width(NUM_SLAVES);
    localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST =
        CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    logic [NUM_SLAVES-1:0]            w_hit;
    logic [SEL_WIDTH-1:0]             w_sel;
    logic                             w_any_hit;
    logic [NUM_SLAVES*ADDR_WIDTH-1:0] w_rebased;
    logic [DATA_WIDTH-1:0]            w_sel_rdata;
    logic                             w_sel_ready;

    state_t                           r_state;
    logic [NUM_SLAVES-1:0]            r_hit;
    logic [SEL_WIDTH-1:0]             r_sel;
    logic                             r_write;
    logic [CNT_WIDTH-1:0]             r_cnt;
    logic [DATA_WIDTH-1:0]            r_m_rdata;
    logic                             r_m_ready;
    logic                             r_m_error;
    logic [NUM_SLAVES*ADDR_WIDTH-1:0] r_s_addr;
    logic [DATA_WIDTH-1:0]            r_s_wdata;
    logic [NUM_SLAVES-1:0]            r_s_read;
    logic [NUM_SLAVES-1:0]            r_s_write;

    region_decoder #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .NUM_SLAVES  (NUM_SLAVES),
        .SEL_WIDTH   (SEL_WIDTH),
        .SLAVE_BASE  (SLAVE_BASE),
        .SLAVE_LIMIT (SLAVE_LIMIT)
    ) u_decoder (
        .i_addr    (bus.m_addr),
        .o_hit     (w_hit),
        .o_sel     (w_sel),
        .o_any_hit (w_any_hit)
    );

    // Rebased address for every slave; subtraction wraps modulo 2^ADDR_WIDTH.
    always_comb begin
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_rebased[i*ADDR_WIDTH +: ADDR_WIDTH] =
                bus.m_addr - SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // Only the latched target's ready and read data are looked at.
    always_comb begin
        w_sel_ready = |(bus.s_ready & r_hit);
        w_sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_sel_rdata = (r_sel == SEL_WIDTH'(i)) ? bus.s_rdata[i*DATA_WIDTH +: DATA_WIDTH]
                                                   : w_sel_rdata;
        end
    end

    // Handshake FSM, request latches, timeout counter and all output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_hit     <= '0;
            r_sel     <= '0;
            r_write   <= 1'b0;
            r_cnt     <= '0;
            r_m_rdata <= '0;
            r_m_ready <= 1'b0;
            r_m_error <= 1'b0;
            r_s_addr  <= '0;
            r_s_wdata <= '0;
            r_s_read  <= '0;
            r_s_write <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.m_read || bus.m_write) begin
                        r_s_addr  <= w_rebased;
                        r_s_wdata <= bus.m_wdata;
                        r_write   <= bus.m_write;
                        r_hit     <= w_hit;
                        r_sel     <= w_sel;
                        r_cnt     <= '0;
                        // A simultaneous read and write is rejected like an unmapped address.
                        if (w_any_hit && !(bus.m_read && bus.m_write)) begin
                            r_state   <= ST_ACCESS;
                            r_s_read  <= bus.m_write ? '0 : w_hit;
                            r_s_write <= bus.m_write ? w_hit : '0;
                        end else begin
                            r_state   <= ST_ERR;
                            r_m_ready <= 1'b1;
                            r_m_error <= 1'b1;
                            r_m_rdata <= '0;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (w_sel_ready) begin
                        r_state   <= ST_RESP;
                        r_s_read  <= '0;
                        r_s_write <= '0;
                        r_m_ready <= 1'b1;
                        r_m_error <= 1'b0;
                        r_m_rdata <= r_write ? '0 : w_sel_rdata;
                    end else if ((TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST)) begin
                        r_state   <= ST_ERR;
                        r_s_read  <= '0;
                        r_s_write <= '0;
                        r_m_ready <= 1'b1;
                        r_m_error <= 1'b1;
                        r_m_rdata <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_WIDTH'(1);
                    end
                end
                ST_RESP, ST_ERR: begin
                    r_state   <= ST_IDLE;
                    r_m_ready <= 1'b0;
                    r_m_error <= 1'b0;
                    r_m_rdata <= '0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_s_read  <= '0;
                    r_s_write <= '0;
                    r_m_ready <= 1'b0;
                    r_m_error <= 1'b0;
                    r_m_rdata <= '0;
                end
            endcase
        end
    end

    assign bus.m_rdata = r_m_rdata;
    assign bus.m_ready = r_m_ready;
    assign bus.m_error = r_m_error;
    assign bus.s_addr  = r_s_addr;
    assign bus.s_wdata = r_s_wdata;
    assign bus.s_read  = r_s_read;
    assign bus.s_write = r_s_write;

endmodule

// File: tb/tb_bus_region_router.sv
// Directed bench for bus_region_router: default map (dut_a) and a narrowed IO region
// with a 4-cycle timeout (dut_b), both fed from the same stimulus.
module tb_bus_region_router;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_read;
    logic        m_write;
    logic [63:0] s_rdata;
    logic [1:0]  s_ready;
    int          sel_dut;
    int          n_chk = 0;
    int          n_err = 0;

    int          cyc;
    int          stb;
    logic [31:0] rdat;
    logic        err;
    logic [63:0] sadr;
    logic [31:0] swd;
    logic [1:0]  rseen;
    logic [1:0]  wseen;

    always #5 clk = ~clk;

    bus_region_router_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(2)) if_a ();
    bus_region_router_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(2)) if_b ();

    assign if_a.m_addr  = m_addr;
    assign if_a.m_wdata = m_wdata;
    assign if_a.m_read  = m_read;
    assign if_a.m_write = m_write;
    assign if_a.s_rdata = s_rdata;
    assign if_a.s_ready = s_ready;
    assign if_b.m_addr  = m_addr;
    assign if_b.m_wdata = m_wdata;
    assign if_b.m_read  = m_read;
    assign if_b.m_write = m_write;
    assign if_b.s_rdata = s_rdata;
    assign if_b.s_ready = s_ready;

    bus_region_router #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(2),
        .SLAVE_BASE({32'hC000_0000, 32'h0000_0000}),
        .SLAVE_LIMIT({32'hFFFF_FFFF, 32'hBFFF_FFFF}),
        .TIMEOUT_CYCLES(256)
    ) dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));

    bus_region_router #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(2),
        .SLAVE_BASE({32'hC000_0000, 32'h0000_0000}),
        .SLAVE_LIMIT({32'hCFFF_FFFF, 32'hBFFF_FFFF}),
        .TIMEOUT_CYCLES(4)
    ) dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));

    wire [31:0] obs_m_rdata = (sel_dut == 0) ? if_a.m_rdata : if_b.m_rdata;
    wire        obs_m_ready = (sel_dut == 0) ? if_a.m_ready : if_b.m_ready;
    wire        obs_m_error = (sel_dut == 0) ? if_a.m_error : if_b.m_error;
    wire [63:0] obs_s_addr  = (sel_dut == 0) ? if_a.s_addr  : if_b.s_addr;
    wire [31:0] obs_s_wdata = (sel_dut == 0) ? if_a.s_wdata : if_b.s_wdata;
    wire [1:0]  obs_s_read  = (sel_dut == 0) ? if_a.s_read  : if_b.s_read;
    wire [1:0]  obs_s_write = (sel_dut == 0) ? if_a.s_write : if_b.s_write;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One transaction, started at a negedge. The addressed slave raises ready once its
    // strobe has been seen rdy_after times (0 = never); noise drives other slaves' ready.
    // cyc counts cycles with the request presented, including the m_ready cycle.
    task automatic run_req(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic rd, input logic wr, input int slv,
                           input int rdy_after, input logic [1:0] noise,
                           output int o_cyc, output int o_stb, output logic [31:0] o_rdata,
                           output logic o_err, output logic [63:0] o_saddr,
                           output logic [31:0] o_swdata,
                           output logic [1:0] o_rseen, output logic [1:0] o_wseen);
        logic [1:0] sel_bit;
        bit         done;
        int         k;
        sel_bit  = 2'b01 << slv;
        done     = 1'b0;
        k        = 0;
        o_cyc    = 0;
        o_stb    = 0;
        o_rdata  = 32'h0;
        o_err    = 1'b0;
        o_saddr  = 64'h0;
        o_swdata = 32'h0;
        o_rseen  = 2'b00;
        o_wseen  = 2'b00;
        m_addr   = addr;
        m_wdata  = wdata;
        m_read   = rd;
        m_write  = wr;
        s_ready  = noise & ~sel_bit;
        while (!done && k < 30) begin
            k++;
            @(negedge clk);
            o_rseen = o_rseen | obs_s_read;
            o_wseen = o_wseen | obs_s_write;
            if ((obs_s_read | obs_s_write) != 2'b00) begin
                o_stb++;
                o_saddr  = obs_s_addr;
                o_swdata = obs_s_wdata;
            end
            if (obs_m_ready) begin
                done    = 1'b1;
                o_cyc   = k + 1;
                o_rdata = obs_m_rdata;
                o_err   = obs_m_error;
            end else begin
                s_ready = ((rdy_after > 0 && o_stb >= rdy_after) ? sel_bit : 2'b00) |
                          (noise & ~sel_bit);
            end
        end
        check("ready_within_budget", {63'h0, done}, 64'h1);
        m_read  = 1'b0;
        m_write = 1'b0;
        s_ready = 2'b00;
    endtask

    // The cycle after a completion must not repeat m_ready.
    task automatic check_single(input string tag);
        @(negedge clk);
        check(tag, {63'h0, obs_m_ready}, 64'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        m_addr  = 32'h0;
        m_wdata = 32'h0;
        m_read  = 1'b0;
        m_write = 1'b0;
        s_rdata = {32'hCAFE_0001, 32'hDEAD_BEEF};
        s_ready = 2'b00;
        sel_dut = 0;
        repeat (3) @(negedge clk);

        check("rst_a_ready", {63'h0, if_a.m_ready}, 64'h0);
        check("rst_a_error", {63'h0, if_a.m_error}, 64'h0);
        check("rst_a_rdata", {32'h0, if_a.m_rdata}, 64'h0);
        check("rst_a_saddr", if_a.s_addr, 64'h0);
        check("rst_a_strb",  {60'h0, if_a.s_read, if_a.s_write}, 64'h0);
        check("rst_b_outs",  {if_b.s_wdata, 26'h0, if_b.m_ready, if_b.m_error,
                              if_b.s_read, if_b.s_write}, 64'h0);
        reset = 1'b0;
        @(negedge clk);

        // Read from memory, slave ready on its first strobe cycle.
        run_req(32'h0000_0010, 32'h0, 1'b1, 1'b0, 0, 1, 2'b00,
                cyc, stb, rdat, err, sadr, swd, rseen, wseen);
        check("rd_latency", 64'(cyc), 64'd3);
        check("rd_rdata",   {32'h0, rdat}, 64'hDEAD_BEEF);
        check("rd_error",   {63'h0, err}, 64'h0);
        check("rd_strobe",  {60'h0, rseen, wseen}, 64'b0100);
        check("rd_saddr0",  {32'h0, sadr[31:0]}, 64'h10);
        check("rd_saddr1_wrap", {32'h0, sadr[63:32]}, 64'h4000_0010);
        check_single("rd_single");

        // IO write, slave ready after 5 strobe cycles; slave0 ready must be ignored.
        run_req(32'hC000_0004, 32'h55, 1'b0, 1'b1, 1, 5, 2'b01,
                cyc, stb, rdat, err, sadr, swd, rseen, wseen);
        check("wr_strobe",  {60'h0, rseen, wseen}, 64'b0010);
        check("wr_strb_len", 64'(stb), 64'd5);
        check("wr_latency", 64'(cyc), 64'd7);
        check("wr_saddr1",  {32'h0, sadr[63:32]}, 64'h4);
        check("wr_wdata",   {32'h0, swd}, 64'h55);
        check("wr_rdata",   {32'h0, rdat}, 64'h0);
        check("wr_error",   {63'h0, err}, 64'h0);
        check_single("wr_single");

        // Region boundaries of the default map.
        run_req(32'hBFFF_FFFF, 32'h0, 1'b1, 1'b0, 0, 1, 2'b00,
                cyc, stb, rdat, err, sadr, swd, rseen, wseen);
        check("mem_top_sel",   {62'h0, rseen}, 64'b01);
        check("mem_top_saddr", {32'h0, sadr[31:0]}, 64'hBFFF_FFFF);
        check_single("mem_top_single");
        run_req(32'hC000_0000, 32'h0, 1'b1, 1'b0, 1, 1, 2'b00,
                cyc, stb, rdat, err, sadr, swd, rseen, wseen);
        check("io_base_sel",   {62'h0, rseen}, 64'b10);
        check("io_base_rdata", {32'h0, rdat}, 64'hCAFE_0001);
        check("io_base_saddr", {32'h0, sadr[63:32]}, 64'h0);
        check_single("io_base_single");

        // Read and write together: error, no strobe.
        run_req(32'h0000_0010, 32'h0, 1'b1, 1'b1, 0, 1, 2'b00,
                cyc, stb, rdat, err, sadr, swd, rseen, wseen);
        check("rw_error",   {63'h0, err}, 64'h1);
        check("rw_nostrb",  64'(stb), 64'd0);
        check("rw_latency", 64'(cyc), 64'd2);
        check_single("rw_single");

        // Second instance: narrowed IO region and 4-cycle timeout.
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset   = 1'b0;
        sel_dut = 1;
        @(negedge clk);

        run_req(32'hD000_0000, 32'h0, 1'b1, 1'b0, 1, 1, 2'b00,
                cyc, stb, rdat, err, sadr, swd, rseen, wseen);
        check("unmap_error",  {63'h0, err}, 64'h1);
        check("unmap_nostrb", {60'h0, rseen, wseen}, 64'h0);
        check("unmap_rdata",  {32'h0, rdat}, 64'h0);
        check_single("unmap_single");

        run_req(32'h0000_0010, 32'h0, 1'b1, 1'b0, 0, 0, 2'b10,
                cyc, stb, rdat, err, sadr, swd, rseen, wseen);
        check("to_strb_len", 64'(stb), 64'd4);
        check("to_error",    {63'h0, err}, 64'h1);
        check("to_latency",  64'(cyc), 64'd6);
        check("to_rdata",    {32'h0, rdat}, 64'h0);
        check_single("to_single");

        run_req(32'h0000_0020, 32'h0, 1'b1, 1'b0, 0, 1, 2'b00,
                cyc, stb, rdat, err, sadr, swd, rseen, wseen);
        check("after_to_latency", 64'(cyc), 64'd3);
        check("after_to_rdata",   {32'h0, rdat}, 64'hDEAD_BEEF);
        check("after_to_error",   {63'h0, err}, 64'h0);
        check_single("after_to_single");

        // Reset while the access is outstanding.
        m_addr = 32'h0000_0030;
        m_read = 1'b1;
        @(negedge clk);
        check("mid_strobe_on", {62'h0, obs_s_read}, 64'b01);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_outs", {26'h0, obs_m_ready, obs_m_error, obs_s_read, obs_s_write}, 64'h0);
        check("mid_rst_saddr", obs_s_addr, 64'h0);
        m_read = 1'b0;
        reset  = 1'b0;
        @(negedge clk);
        check("mid_rst_noready", {62'h0, obs_m_ready, obs_s_read[0]}, 64'h0);

        run_req(32'h0000_0040, 32'h0, 1'b1, 1'b0, 0, 1, 2'b00,
                cyc, stb, rdat, err, sadr, swd, rseen, wseen);
        check("post_rst_latency", 64'(cyc), 64'd3);
        check("post_rst_saddr",   {32'h0, sadr[31:0]}, 64'h40);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
